// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the valid/ready memory bus initiator and its
// lane alignment logic.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_WAIT = 2'd1,
    RESP     = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  function automatic logic [3:0] strobe_for(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  strobe_for = 4'b0001 << addr_lo;
      SIZE_H:  strobe_for = 4'b0011 << addr_lo;
      SIZE_W:  strobe_for = 4'b1111;
      default: strobe_for = 4'b0000;
    endcase
  endfunction

  // Only alignment is judged here; the reserved size code is rejected separately.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    case (size)
      SIZE_H:  misaligned = addr_lo[0];
      SIZE_W:  misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_initiator_lane_align.sv
// Combinational byte-lane logic: store replication/strobes and load
// extraction with sign or zero extension. Also used by the DMA initiator.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        zero_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] store_lanes,
  output logic [3:0]  store_strb,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    store_lanes = store_data;
    store_strb  = strobe_for(size, addr_lo);
    load_byte   = load_word[{addr_lo, 3'b000} +: 8];
    load_half   = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    load_data   = load_word;
    case (size)
      SIZE_B: begin
        store_lanes = {4{store_data[7:0]}};
        load_data   = zero_ext ? {24'd0, load_byte}
                               : {{24{load_byte[7]}}, load_byte};
      end
      SIZE_H: begin
        store_lanes = {2{store_data[15:0]}};
        load_data   = zero_ext ? {16'd0, load_half}
                               : {{16{load_half[15]}}, load_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// Single-outstanding load/store initiator for the valid/ready memory bus,
// with request alignment checks and a bus-wait timeout.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       size_q;
  logic [1:0]       addr_lo_q;
  logic             zero_ext_q;
  logic             write_q;
  logic             illegal;

  logic [1:0]  align_size;
  logic [1:0]  align_addr_lo;
  logic        align_zero_ext;
  logic [31:0] store_lanes;
  logic [3:0]  store_strb;
  logic [31:0] load_data;

  // In IDLE the aligner shapes the incoming store; afterwards it extracts
  // the load from the latched command, so one instance serves both.
  assign align_size     = (state == IDLE) ? req_size     : size_q;
  assign align_addr_lo  = (state == IDLE) ? req_addr[1:0] : addr_lo_q;
  assign align_zero_ext = (state == IDLE) ? req_unsigned : zero_ext_q;

  assign illegal   = (req_size == SIZE_ILLEGAL) || misaligned(req_size, req_addr[1:0]);
  assign req_ready = (state == IDLE) && reset_n;

  mem_lane_align u_align (
    .size        (align_size),
    .addr_lo     (align_addr_lo),
    .zero_ext    (align_zero_ext),
    .store_data  (req_wdata),
    .load_word   (mem_rdata),
    .store_lanes (store_lanes),
    .store_strb  (store_strb),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      size_q     <= 2'd0;
      addr_lo_q  <= 2'd0;
      zero_ext_q <= 1'b0;
      write_q    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            size_q     <= req_size;
            addr_lo_q  <= req_addr[1:0];
            zero_ext_q <= req_unsigned;
            write_q    <= req_write;
            if (illegal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state     <= BUS_WAIT;
              wait_cnt  <= '0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_write ? store_lanes : 32'd0;
              mem_wstrb <= req_write ? store_strb  : 4'd0;
            end
          end
        end
        BUS_WAIT: begin
          if (mem_ready) begin
            state      <= RESP;
            mem_valid  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write_q ? 32'd0 : load_data;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
            state      <= RESP;
            mem_valid  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Scoreboard bench for mem_bus_initiator: directed commands push expected
// responses and bus beats; separate monitors pop and compare them.
module tb_mem_bus_initiator;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } resp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        write;
  } bus_exp_t;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  logic        resp_rdy;
  logic        late_rdy;
  logic        resp_en;
  int          ready_delay;
  logic [31:0] model [int];

  int          checks;
  int          fails;
  int          cyc;
  int          resp_seen;
  int          resp_cyc_log[$];
  resp_exp_t   resp_q[$];
  bus_exp_t    bus_q[$];
  logic        need_gap;
  logic        seen_low;

  logic [31:0] b2b_addr [10] = '{32'h100, 32'h100, 32'h101, 32'h100, 32'h100,
                                 32'h102, 32'h103, 32'h102, 32'h100, 32'h102};
  logic [1:0]  b2b_size [10] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd1,
                                 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
  logic        b2b_zext [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] b2b_exp  [10] = '{32'h8001BEEF, 32'h0000BEEF, 32'hFFFFFFBE, 32'h000000EF,
                                 32'hFFFFBEEF, 32'h00000001, 32'h00000080, 32'h00008001,
                                 32'hFFFFFFEF, 32'hFFFF8001};

  assign mem_ready = resp_rdy | late_rdy;

  mem_bus_initiator #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int idx = int'(addr >> 2);
    return model.exists(idx) ? model[idx] : 32'd0;
  endfunction

  // Responder: raises mem_ready in the ready_delay-th cycle of mem_valid.
  initial begin
    int rcnt = 0;
    resp_rdy  = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid && !resp_rdy) begin
        rcnt++;
        if (resp_en && rcnt >= ready_delay) begin
          resp_rdy  = 1'b1;
          mem_rdata = model_read(mem_addr);
        end
      end else begin
        resp_rdy = 1'b0;
        rcnt     = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && mem_valid && mem_ready && mem_wstrb != 4'd0) begin
      automatic int idx = int'(mem_addr >> 2);
      automatic logic [31:0] w = model_read(mem_addr);
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      model[idx] = w;
    end
  end

  // Bus monitor: each completed beat is checked against the next expected beat.
  initial begin
    need_gap = 1'b0;
    seen_low = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_valid) begin
          if (need_gap) begin
            check_output("mem_valid_gap", {31'd0, seen_low}, 32'd1);
            need_gap = 1'b0;
          end
          if (mem_ready) begin
            need_gap = 1'b1;
            seen_low = 1'b0;
            if (bus_q.size() == 0) begin
              check_output("unexpected_bus_beat", mem_addr, 32'hFFFF_FFFF);
            end else begin
              automatic bus_exp_t e = bus_q.pop_front();
              check_output("mem_addr", mem_addr, e.addr);
              check_output("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
              if (e.write) check_output("mem_wdata", mem_wdata, e.wdata);
            end
          end
        end else begin
          seen_low = 1'b1;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && resp_valid) begin
        resp_seen++;
        resp_cyc_log.push_back(cyc);
        if (resp_q.size() == 0) begin
          check_output("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
        end else begin
          automatic resp_exp_t e = resp_q.pop_front();
          check_output("resp_rdata", resp_rdata, e.rdata);
          check_output("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check_output("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
          check_output("mem_valid_at_resp", {31'd0, mem_valid}, 32'd0);
        end
      end
    end
  end

  // Drives one command and waits for acceptance; returns #1 after the accept edge.
  task automatic apply_stimulus(input logic wr, input logic [1:0] sz, input logic zext,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input logic [31:0] exp_wdata,
                                input logic [3:0] exp_wstrb, input bit push_resp,
                                input bit push_bus, input bit keep);
    bit ok = 0;
    int acc;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = zext;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check_output("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    #1;
    if (push_resp) resp_q.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat, acc: acc});
    if (push_bus) bus_q.push_back('{addr: addr & 32'hFFFF_FFFC, wdata: exp_wdata,
                                    wstrb: exp_wstrb, write: wr});
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 200 && resp_seen < target; i++) @(posedge clk);
    #1;
    check_output("resp_count", 32'(resp_seen), 32'(target));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int vcnt;
    checks = 0; fails = 0; cyc = 0; resp_seen = 0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    late_rdy = 1'b0; resp_en = 1'b1; ready_delay = 4;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check_output("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_output("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_output("reset_resp_rdata", resp_rdata, 32'd0);
    check_output("reset_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("release_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] word store/load");
    apply_stimulus(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'd0, 0, 5, 32'hDEADBEEF, 4'hF, 1, 1, 0);
    wait_resp(1);
    apply_stimulus(0, 2'd2, 0, 32'h100, 32'd0, 32'hDEADBEEF, 0, 5, 32'd0, 4'h0, 1, 1, 0);
    wait_resp(2);

    $display("[TB] byte store and loads");
    apply_stimulus(1, 2'd0, 0, 32'h103, 32'h12345680, 32'd0, 0, 5, 32'h80808080, 4'h8, 1, 1, 0);
    wait_resp(3);
    apply_stimulus(0, 2'd0, 0, 32'h103, 32'd0, 32'hFFFFFF80, 0, 5, 32'd0, 4'h0, 1, 1, 0);
    wait_resp(4);
    apply_stimulus(0, 2'd0, 1, 32'h103, 32'd0, 32'h00000080, 0, 5, 32'd0, 4'h0, 1, 1, 0);
    wait_resp(5);

    $display("[TB] half store/load and illegal requests");
    apply_stimulus(1, 2'd1, 0, 32'h102, 32'hAAAA8001, 32'd0, 0, 5, 32'h80018001, 4'hC, 1, 1, 0);
    wait_resp(6);
    apply_stimulus(0, 2'd1, 0, 32'h102, 32'd0, 32'hFFFF8001, 0, 5, 32'd0, 4'h0, 1, 1, 0);
    wait_resp(7);
    apply_stimulus(0, 2'd1, 0, 32'h101, 32'd0, 32'd0, 1, 1, 32'd0, 4'h0, 1, 0, 0);
    check_output("illegal_no_mem_valid", {31'd0, mem_valid}, 32'd0);
    wait_resp(8);
    apply_stimulus(0, 2'd3, 0, 32'h100, 32'd0, 32'd0, 1, 1, 32'd0, 4'h0, 1, 0, 0);
    wait_resp(9);
    apply_stimulus(0, 2'd2, 0, 32'h102, 32'd0, 32'd0, 1, 1, 32'd0, 4'h0, 1, 0, 0);
    wait_resp(10);

    $display("[TB] timeout");
    resp_en = 1'b0;
    apply_stimulus(0, 2'd2, 0, 32'h104, 32'd0, 32'd0, 1, 9, 32'd0, 4'h0, 1, 0, 0);
    vcnt = 0;
    for (int k = 1; k <= 11; k++) begin
      if (mem_valid) vcnt++;
      @(posedge clk);
      #1;
    end
    check_output("timeout_valid_cycles", 32'(vcnt), 32'd8);
    late_rdy = 1'b1;
    @(posedge clk);
    #1;
    late_rdy = 1'b0;
    check_output("late_ready_ignored", {31'd0, req_ready}, 32'd1);
    wait_resp(11);
    resp_en = 1'b1;

    $display("[TB] reset mid-transaction");
    apply_stimulus(0, 2'd2, 0, 32'h100, 32'd0, 32'd0, 0, 0, 32'd0, 4'h0, 0, 0, 0);
    @(posedge clk);
    #3;
    check_output("pre_reset_mem_valid", {31'd0, mem_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("async_drop_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_output("in_reset_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check_output("no_resp_after_reset", 32'(resp_seen), 32'd11);
    apply_stimulus(0, 2'd2, 0, 32'h100, 32'd0, 32'h8001BEEF, 0, 5, 32'd0, 4'h0, 1, 1, 0);
    wait_resp(12);

    $display("[TB] back-to-back loads");
    resp_cyc_log.delete();
    base = resp_seen;
    for (int i = 0; i < 10; i++)
      apply_stimulus(0, b2b_size[i], b2b_zext[i], b2b_addr[i], 32'd0, b2b_exp[i], 0, 5,
                     32'd0, 4'h0, 1, 1, (i != 9));
    wait_resp(base + 10);
    if (resp_cyc_log.size() == 10)
      for (int i = 1; i < 10; i++)
        check_output("b2b_period", 32'(resp_cyc_log[i] - resp_cyc_log[i-1]), 32'd6);
    else
      check_output("b2b_resp_log", 32'(resp_cyc_log.size()), 32'd10);

    repeat (5) @(posedge clk);
    #1;
    check_output("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    check_output("bus_queue_empty", 32'(bus_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
